// File: rtl/add8_pkg.sv
// Shared constants and plane/vector types for the add8 datapath
// (nibble adder, pack stage and writeback).
package add8_pkg;

  localparam int ADD8_LANES  = 32;
  localparam int ADD8_NIB_W  = 4;
  localparam int ADD8_BYTE_W = 8;

  typedef logic [ADD8_LANES*ADD8_NIB_W-1:0]  nib_plane_t;
  typedef logic [ADD8_LANES*ADD8_BYTE_W-1:0] byte_vec_t;

endpackage

// File: rtl/add8_pack_fifo.sv
// Generic synchronous FIFO, WIDTH x DEPTH, with a registered occupancy count.
// in_ready depends only on registered state, so a full FIFO refuses a push
// even in a cycle where it pops. Storage resets to zero so that out_data
// reads zero after reset.
module add8_pack_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next-state: write at wr_ptr, advance pointers, track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // State registers; reset empties the FIFO and discards stored entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/add8_pack.sv
// Output stage after the 32-lane nibble adder: re-interleaves the dst0/dst1
// nibble planes into int8 bytes and buffers them, with sign and last flags,
// in a small FIFO feeding the writeback valid/ready stream.
// Optional statistics counters are built when ADD8_PACK_STAT_EN is defined.
module add8_pack
  import add8_pkg::*;
#(
  parameter int LANES = ADD8_LANES,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*4-1:0]   dst0,
  input  logic [LANES*4-1:0]   dst1,
  input  logic                 in_sign,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*8-1:0]   out_data,
  output logic                 out_sign,
  output logic                 out_last
`ifdef ADD8_PACK_STAT_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_beats,
  output logic [31:0]          stat_stall
`endif
);

  localparam int FIFO_W = LANES*8 + 2;

  logic [LANES*8-1:0] packed_data;
  logic [FIFO_W-1:0]  fifo_in;
  logic [FIFO_W-1:0]  fifo_out;

  // Plain concatenation per lane; the adder has already clipped results.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign packed_data[8*i +: 8] = {dst1[4*i +: 4], dst0[4*i +: 4]};
  end

  assign fifo_in = {in_sign, in_last, packed_data};

  add8_pack_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (fifo_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out)
  );

  assign out_data = fifo_out[LANES*8-1:0];
  assign out_last = fifo_out[LANES*8];
  assign out_sign = fifo_out[LANES*8+1];

`ifdef ADD8_PACK_STAT_EN
  logic [31:0] stat_beats_q, stat_beats_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Saturating pop and stall counters; clear wins over an increment.
  always_comb begin
    stat_beats_d = stat_beats_q;
    stat_stall_d = stat_stall_q;
    if (stat_clr) begin
      stat_beats_d = '0;
      stat_stall_d = '0;
    end else begin
      if (out_valid && out_ready && (stat_beats_q != 32'hFFFF_FFFF)) begin
        stat_beats_d = stat_beats_q + 32'd1;
      end
      if (out_valid && !out_ready && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_d = stat_stall_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_beats_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_beats_q <= stat_beats_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_beats = stat_beats_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_add8_pack.sv
// Testbench for add8_pack: directed scenarios plus random traffic, checked
// against a queue-based reference model of the buffered byte stream.
module tb_add8_pack;
  import add8_pkg::*;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dst0;
  logic [127:0] dst1;
  logic         in_sign;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;
  logic         out_sign;
  logic         out_last;
`ifdef ADD8_PACK_STAT_EN
  logic         stat_clr;
  logic [31:0]  stat_beats;
  logic [31:0]  stat_stall;
`endif

  always #5 clk = ~clk;

  add8_pack dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dst0      (dst0),
    .dst1      (dst1),
    .in_sign   (in_sign),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_last  (out_last)
`ifdef ADD8_PACK_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .stat_beats(stat_beats),
    .stat_stall(stat_stall)
`endif
  );

  typedef struct {
    logic [255:0] data;
    logic         sign;
    logic         last;
  } beat_t;

  beat_t       mq[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          dut_pops = 0;
  bit          accepted;
  logic [31:0] exp_beats = 0;
  logic [31:0] exp_stall = 0;

  // Each byte's value is high nibble * 16 + low nibble.
  function automatic logic [255:0] pack_ref(input logic [127:0] d0, input logic [127:0] d1);
    logic [255:0] r;
    int unsigned  v;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      v = 16 * int'(d1 >> (4*i) & 128'hF) + int'(d0 >> (4*i) & 128'hF);
      r = r | (256'(v) << (8*i));
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check outputs against the
  // model, then let the model advance on the rising edge.
  task automatic cycle(input logic iv, input logic [127:0] d0, input logic [127:0] d1,
                       input logic s, input logic l, input logic ordy, input logic clr = 1'b0);
    bit do_push, do_pop, stall;
    beat_t b;
    in_valid  = iv;
    dst0      = d0;
    dst1      = d1;
    in_sign   = s;
    in_last   = l;
    out_ready = ordy;
`ifdef ADD8_PACK_STAT_EN
    stat_clr  = clr;
`endif
    #1;
    chk("in_ready", 256'(in_ready), 256'(mq.size() != DEPTH));
    chk("out_valid", 256'(out_valid), 256'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_data", out_data, mq[0].data);
      chk("out_sign", 256'(out_sign), 256'(mq[0].sign));
      chk("out_last", 256'(out_last), 256'(mq[0].last));
    end
`ifdef ADD8_PACK_STAT_EN
    chk("stat_beats", 256'(stat_beats), 256'(exp_beats));
    chk("stat_stall", 256'(stat_stall), 256'(exp_stall));
`endif
    if (out_valid && out_ready) dut_pops++;
    do_push = iv && (mq.size() != DEPTH);
    do_pop  = (mq.size() != 0) && ordy;
    stall   = (mq.size() != 0) && !ordy;
    b.data  = pack_ref(d0, d1);
    b.sign  = s;
    b.last  = l;
    @(posedge clk);
    if (clr) begin
      exp_beats = 0;
      exp_stall = 0;
    end else begin
      if (do_pop && exp_beats != 32'hFFFF_FFFF) exp_beats++;
      if (stall && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(b);
    accepted = do_push;
    @(negedge clk);
  endtask

  logic [127:0] pat0, pat_a;
  logic [127:0] b1, b2, b3;
  int           pops0;

  initial begin
    rst = 1'b1; in_valid = 0; dst0 = '0; dst1 = '0; in_sign = 0; in_last = 0; out_ready = 0;
`ifdef ADD8_PACK_STAT_EN
    stat_clr = 0;
`endif
    @(negedge clk);
    #1;
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_data", out_data, 256'(0));
    chk("rst_out_sign", 256'(out_sign), 256'(0));
    chk("rst_out_last", 256'(out_last), 256'(0));
    @(negedge clk);
    rst = 1'b0;

    // Interleave pattern.
    pat0  = 128'h0123456789ABCDEF0123456789ABCDEF;
    pat_a = {32{4'hA}};
    cycle(1, pat0, pat_a, 1, 0, 1);
    #1;
    chk("interleave_valid", 256'(out_valid), 256'(1));
    chk("interleave_byte0", 256'(out_data[7:0]), 256'(8'hAF));
    chk("interleave_byte1", 256'(out_data[15:8]), 256'(8'hAE));
    cycle(0, '0, '0, 0, 0, 1);

    // Fill with back-pressure; third beat held upstream until space opens.
    b1 = rnd128(); b2 = rnd128(); b3 = rnd128();
    cycle(1, b1, b1, 0, 0, 0);
    cycle(1, b2, b2, 1, 0, 0);
    #1;
    chk("full_in_ready", 256'(in_ready), 256'(0));
    cycle(1, b3, b3, 0, 1, 0);
    cycle(1, b3, b3, 0, 1, 0);
    // Full with pop in the same cycle: pop happens, push refused.
    cycle(1, b3, b3, 0, 1, 1);
    chk("full_pop_no_push", 256'(accepted), 256'(0));
    #1;
    chk("after_full_pop_in_ready", 256'(in_ready), 256'(1));
    chk("after_full_pop_head", out_data, pack_ref(b2, b2));
    cycle(1, b3, b3, 0, 1, 1);
    cycle(0, '0, '0, 0, 0, 1);
    chk("drained_valid", 256'(out_valid), 256'(0));

    // Steady stream with incrementing data.
    pops0 = dut_pops;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 128'(i + 1), 128'(i * 3), i[0], i[1], 1);
    end
    chk("stream_pops", 256'(dut_pops - pops0), 256'(99));
    cycle(0, '0, '0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    // Reset mid-stream with two entries held.
    cycle(1, rnd128(), rnd128(), 1, 1, 0);
    cycle(1, rnd128(), rnd128(), 1, 1, 0);
    cycle(0, '0, '0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_in_ready", 256'(in_ready), 256'(1));
    mq.delete();
    exp_beats = 0;
    exp_stall = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(0, '0, '0, 0, 0, 1);
    cycle(0, '0, '0, 0, 0, 1);
    b1 = rnd128();
    cycle(1, b1, b1, 0, 1, 1);
    #1;
    chk("post_rst_first", out_data, pack_ref(b1, b1));
    cycle(0, '0, '0, 0, 0, 1);

`ifdef ADD8_PACK_STAT_EN
    cycle(0, '0, '0, 0, 0, 0, 1);
    cycle(1, rnd128(), rnd128(), 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, '0, '0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, rnd128(), rnd128(), 0, 0, 1);
    #1;
    chk("stat_beats_5", 256'(stat_beats), 256'(5));
    chk("stat_stall_7", 256'(stat_stall), 256'(7));
    cycle(0, '0, '0, 0, 0, 1, 1);
    #1;
    chk("stat_clr_beats", 256'(stat_beats), 256'(0));
    chk("stat_clr_stall", 256'(stat_stall), 256'(0));
    cycle(0, '0, '0, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
